// File: rtl/flp_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flp_accum: floating-point stream accumulator (one add per accepted beat)  |
// | Optional macro FLP_ACCUM_STICKY_EN builds the sticky NaN/inf flags.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module flp_accum #(
  parameter int EWIDTH  = 8,
  parameter int SWIDTH  = 23,
  parameter int RSWIDTH = 2,
  parameter int CWIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     i_valid,
  input  logic [EWIDTH+SWIDTH:0]   i_data,
  input  logic                     i_last,
  output logic                     o_ready,
  output logic                     o_valid,
  output logic [EWIDTH+SWIDTH:0]   o_sum,
  output logic [CWIDTH-1:0]        o_count,
  input  logic                     i_ready,
  output logic                     o_nan,
  output logic                     o_inf
);

  localparam int c_fw = 1 + EWIDTH + SWIDTH;
  localparam int c_mw = SWIDTH + 1 + RSWIDTH;
  localparam int c_sw = c_mw + 2;
  localparam int c_xw = EWIDTH + 2;
  localparam logic [EWIDTH-1:0] c_emax = '1;
  localparam logic [c_fw-1:0]   c_qnan = {1'b0, c_emax, 1'b1, {(SWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, OUT = 2'd2} state_t;

  state_t              r_state, w_state_nxt;
  logic [c_fw-1:0]     r_acc, r_sum, w_sum_n;
  logic [CWIDTH-1:0]   r_count, r_ocount, w_count_inc;
  logic                w_accept, w_clear;

  // ---------------- unpack: a is the larger-magnitude operand ----------------
  logic                w_swap, w_sa, w_sb;
  logic [c_fw-1:0]     w_a, w_b;
  logic [EWIDTH-1:0]   w_ea_raw, w_eb_raw, w_ea, w_eb, w_d, w_dcap;
  logic [SWIDTH-1:0]   w_fa, w_fb;
  logic [c_mw-1:0]     w_ma, w_mb;
  logic                w_a_nan, w_b_nan, w_a_inf, w_b_inf;

  assign w_swap   = i_data[c_fw-2:0] > r_acc[c_fw-2:0];
  assign w_a      = w_swap ? i_data : r_acc;
  assign w_b      = w_swap ? r_acc : i_data;
  assign w_sa     = w_a[c_fw-1];
  assign w_sb     = w_b[c_fw-1];
  assign w_ea_raw = w_a[c_fw-2:SWIDTH];
  assign w_eb_raw = w_b[c_fw-2:SWIDTH];
  assign w_fa     = w_a[SWIDTH-1:0];
  assign w_fb     = w_b[SWIDTH-1:0];
  // Subnormals use effective exponent 1 with no hidden bit.
  assign w_ea     = (w_ea_raw == '0) ? {{(EWIDTH-1){1'b0}}, 1'b1} : w_ea_raw;
  assign w_eb     = (w_eb_raw == '0) ? {{(EWIDTH-1){1'b0}}, 1'b1} : w_eb_raw;
  assign w_ma     = {|w_ea_raw, w_fa, {RSWIDTH{1'b0}}};
  assign w_mb     = {|w_eb_raw, w_fb, {RSWIDTH{1'b0}}};
  assign w_a_nan  = (w_ea_raw == c_emax) & (|w_fa);
  assign w_b_nan  = (w_eb_raw == c_emax) & (|w_fb);
  assign w_a_inf  = (w_ea_raw == c_emax) & ~(|w_fa);
  assign w_b_inf  = (w_eb_raw == c_emax) & ~(|w_fb);

  // ---------------- align + iadd (shifted-out bits fold into a sticky LSB) ---
  logic [2*c_mw-1:0]   w_align;
  logic [c_mw:0]       w_as, w_bs;
  logic [c_sw-1:0]     w_add;

  assign w_d      = w_ea - w_eb;
  assign w_dcap   = (w_d > EWIDTH'(c_mw)) ? EWIDTH'(c_mw) : w_d;
  assign w_align  = {w_mb, {c_mw{1'b0}}} >> w_dcap;
  assign w_bs     = {w_align[2*c_mw-1:c_mw], |w_align[c_mw-1:0]};
  assign w_as     = {w_ma, 1'b0};
  assign w_add    = (w_sa == w_sb) ? ({1'b0, w_as} + {1'b0, w_bs})
                                   : ({1'b0, w_as} - {1'b0, w_bs});

  // ---------------- norm ----------------
  logic [c_xw-1:0]     w_lz, w_ea_x, w_sh, w_en, w_efield;
  logic [c_sw-1:0]     w_norm;

  always_comb begin
    w_lz = c_xw'(c_sw);
    for (int i = 0; i < c_sw; i++) begin
      if (w_add[i]) w_lz = c_xw'(c_sw - 1 - i);
    end
  end

  // Left shift is capped so the exponent never drops below 1 (gradual underflow).
  assign w_ea_x   = {2'b00, w_ea};
  assign w_sh     = (w_lz <= w_ea_x) ? w_lz : w_ea_x;
  assign w_norm   = w_add << w_sh;
  assign w_en     = w_ea_x + c_xw'(1) - w_sh;
  assign w_efield = w_norm[c_sw-1] ? w_en : '0;

  // ---------------- round (nearest-even) + pack ----------------
  logic [SWIDTH-1:0]        w_frac_n;
  logic                     w_lsb, w_guard, w_stk, w_inc, w_ovf;
  logic [c_xw+SWIDTH-1:0]   w_rnd;

  assign w_frac_n = w_norm[c_sw-2 -: SWIDTH];
  assign w_lsb    = w_norm[RSWIDTH+2];
  assign w_guard  = w_norm[RSWIDTH+1];
  assign w_stk    = |w_norm[RSWIDTH:0];
  assign w_inc    = w_guard & (w_stk | w_lsb);
  // Carry out of the fraction ripples straight into the exponent field.
  assign w_rnd    = {w_efield, w_frac_n} + {{(c_xw+SWIDTH-1){1'b0}}, w_inc};
  assign w_ovf    = w_rnd[c_xw+SWIDTH-1:SWIDTH] >= {2'b00, c_emax};

  always_comb begin
    w_sum_n = {w_sa, w_rnd[EWIDTH+SWIDTH-1:0]};
    if (w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_sa != w_sb))) begin
      w_sum_n = c_qnan;
    end else if (w_a_inf | w_ovf) begin
      w_sum_n = {w_sa, c_emax, {SWIDTH{1'b0}}};
    end else if (w_add == '0) begin
      w_sum_n = {w_sa & w_sb, {(c_fw-1){1'b0}}};
    end
  end

  // ---------------- control ----------------
  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    o_valid     = 1'b0;
    case (r_state)
      IDLE, ACC: begin
        o_ready = 1'b1;
        if (i_valid) w_state_nxt = i_last ? OUT : ACC;
      end
      OUT: begin
        o_valid = 1'b1;
        if (i_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept    = i_valid & o_ready;
  assign w_clear     = o_valid & i_ready;
  assign w_count_inc = (&r_count) ? r_count : r_count + 1'b1;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_count  <= '0;
      r_sum    <= '0;
      r_ocount <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_acc   <= w_sum_n;
        r_count <= w_count_inc;
        if (i_last) begin
          r_sum    <= w_sum_n;
          r_ocount <= w_count_inc;
        end
      end else if (w_clear) begin
        r_acc   <= '0;
        r_count <= '0;
      end
    end
  end

  assign o_sum   = r_sum;
  assign o_count = r_ocount;

`ifdef FLP_ACCUM_STICKY_EN
  logic r_nan, r_inf, w_in_nan, w_in_inf, w_sn_nan, w_sn_inf;

  assign w_in_nan = (i_data[c_fw-2:SWIDTH] == c_emax) & (|i_data[SWIDTH-1:0]);
  assign w_in_inf = (i_data[c_fw-2:SWIDTH] == c_emax) & ~(|i_data[SWIDTH-1:0]);
  assign w_sn_nan = (w_sum_n[c_fw-2:SWIDTH] == c_emax) & (|w_sum_n[SWIDTH-1:0]);
  assign w_sn_inf = (w_sum_n[c_fw-2:SWIDTH] == c_emax) & ~(|w_sum_n[SWIDTH-1:0]);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_nan <= 1'b0;
      r_inf <= 1'b0;
    end else if (w_accept) begin
      r_nan <= r_nan | w_in_nan | w_sn_nan;
      r_inf <= r_inf | w_in_inf | w_sn_inf;
    end else if (w_clear) begin
      r_nan <= 1'b0;
      r_inf <= 1'b0;
    end
  end

  assign o_nan = r_nan;
  assign o_inf = r_inf;
`else
  assign o_nan = 1'b0;
  assign o_inf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_flp_accum.sv
`default_nettype none
// Bench for flp_accum: directed packets plus random exact-sum packets checked
// against an arithmetic model (values are multiples of 0.25, sums stay exact).
module tb_flp_accum;

`ifdef FLP_ACCUM_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, out_accept = 1'b0;
  logic [31:0] in_data = '0;
  logic        rdy, vld, nan, inf;
  logic [31:0] sum;
  logic [15:0] cnt;

  logic        in_valid_b = 1'b0, in_last_b = 1'b0, out_accept_b = 1'b0;
  logic [31:0] in_data_b = '0;
  logic        rdy_b, vld_b, nan_b, inf_b;
  logic [31:0] sum_b;
  logic [1:0]  cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  flp_accum u0 (
    .clk(clk), .nrst(nrst), .i_valid(in_valid), .i_data(in_data), .i_last(in_last),
    .o_ready(rdy), .o_valid(vld), .o_sum(sum), .o_count(cnt), .i_ready(out_accept),
    .o_nan(nan), .o_inf(inf)
  );

  flp_accum #(.CWIDTH(2)) u1 (
    .clk(clk), .nrst(nrst), .i_valid(in_valid_b), .i_data(in_data_b), .i_last(in_last_b),
    .o_ready(rdy_b), .o_valid(vld_b), .o_sum(sum_b), .o_count(cnt_b), .i_ready(out_accept_b),
    .o_nan(nan_b), .o_inf(inf_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // value = q/4, exactly representable for |q| < 2^24
  function automatic logic [31:0] q_to_fp(input int q);
    logic [31:0] mv, f;
    logic [7:0]  e;
    int          p;
    if (q == 0) return 32'h0;
    mv = (q < 0) ? 32'(-q) : 32'(q);
    p  = 0;
    for (int i = 0; i < 32; i++) if (mv[i]) p = i;
    f = mv << (23 - p);
    e = 8'(127 + p - 2);
    return {(q < 0), e, f[22:0]};
  endfunction

  task automatic send(input logic [31:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!rdy && n < 50) begin
      tick;
      n++;
    end
    if (n >= 50) chk("ready_timeout", {63'b0, rdy}, 64'd1);
    tick;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take(input string tag, input logic [31:0] exp_sum, input logic [31:0] mask,
                      input int exp_cnt, input int hold, input bit exp_nan, input bit exp_inf);
    chk({tag, "_valid"}, {63'b0, vld}, 64'd1);
    chk({tag, "_sum"}, {32'b0, sum & mask}, {32'b0, exp_sum & mask});
    chk({tag, "_count"}, {48'b0, cnt}, 64'(exp_cnt));
    chk({tag, "_nan"}, {63'b0, nan}, {63'b0, STK & exp_nan});
    chk({tag, "_inf"}, {63'b0, inf}, {63'b0, STK & exp_inf});
    for (int i = 0; i < hold; i++) begin
      tick;
      chk({tag, "_hold_valid"}, {63'b0, vld}, 64'd1);
      chk({tag, "_hold_ready"}, {63'b0, rdy}, 64'd0);
      chk({tag, "_hold_sum"}, {32'b0, sum & mask}, {32'b0, exp_sum & mask});
      chk({tag, "_hold_count"}, {48'b0, cnt}, 64'(exp_cnt));
    end
    out_accept = 1'b1;
    tick;
    out_accept = 1'b0;
    chk({tag, "_done_valid"}, {63'b0, vld}, 64'd0);
    chk({tag, "_done_ready"}, {63'b0, rdy}, 64'd1);
    chk({tag, "_done_nan"}, {63'b0, nan}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
    $fatal(1);
  end

  initial begin
    int len, q, qsum, gap;

    // reset state
    repeat (3) tick;
    chk("rst_valid", {63'b0, vld}, 64'd0);
    chk("rst_ready", {63'b0, rdy}, 64'd1);
    chk("rst_sum", {32'b0, sum}, 64'd0);
    chk("rst_count", {48'b0, cnt}, 64'd0);
    chk("rst_nan", {63'b0, nan}, 64'd0);
    chk("rst_inf", {63'b0, inf}, 64'd0);
    chk("rst_count_b", {62'b0, cnt_b}, 64'd0);
    nrst = 1'b1;
    tick;

    // 1 + 2 + 3
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b0);
    send(32'h40400000, 1'b1);
    take("p123", 32'h40C00000, 32'hFFFFFFFF, 3, 0, 1'b0, 1'b0);

    // single element, output back-pressured for 5 cycles
    send(32'hBF800000, 1'b1);
    take("single", 32'hBF800000, 32'hFFFFFFFF, 1, 5, 1'b0, 1'b0);

    // cancellation gives a zero
    send(32'h3F800000, 1'b0);
    send(32'hBF800000, 1'b1);
    take("cancel", 32'h00000000, 32'h7FFFFFFF, 2, 0, 1'b0, 1'b0);

    // inf + -inf is NaN
    send(32'h7F800000, 1'b0);
    send(32'hFF800000, 1'b1);
    chk("nan_frac_nonzero", {63'b0, |sum[22:0]}, 64'd1);
    take("infnan", 32'h7F800000, 32'h7F800000, 2, 0, 1'b1, 1'b1);

    // round to nearest even: ties on 1.0 stay, ties on 1+ulp round up
    send(32'h3F800000, 1'b0);
    send(32'h33800000, 1'b1);
    take("rne_even", 32'h3F800000, 32'hFFFFFFFF, 2, 0, 1'b0, 1'b0);
    send(32'h3F800001, 1'b0);
    send(32'h33800000, 1'b1);
    take("rne_up", 32'h3F800002, 32'hFFFFFFFF, 2, 0, 1'b0, 1'b0);

    // reset mid-packet discards progress
    send(32'h3F800000, 1'b0);
    tick;
    send(32'h3F800000, 1'b0);
    nrst = 1'b0;
    tick;
    chk("midrst_valid", {63'b0, vld}, 64'd0);
    chk("midrst_count", {48'b0, cnt}, 64'd0);
    chk("midrst_sum", {32'b0, sum}, 64'd0);
    nrst = 1'b1;
    tick;
    send(32'h40000000, 1'b1);
    take("fresh", 32'h40000000, 32'hFFFFFFFF, 1, 0, 1'b0, 1'b0);

    // saturating count on a 2-bit counter instance
    for (int i = 0; i < 5; i++) begin
      in_valid_b = 1'b1;
      in_data_b  = 32'h3F800000;
      in_last_b  = (i == 4);
      tick;
    end
    in_valid_b = 1'b0;
    in_last_b  = 1'b0;
    chk("sat_valid", {63'b0, vld_b}, 64'd1);
    chk("sat_count", {62'b0, cnt_b}, 64'd3);
    chk("sat_sum", {32'b0, sum_b}, 64'h40A00000);
    out_accept_b = 1'b1;
    tick;
    out_accept_b = 1'b0;
    chk("sat_done_valid", {63'b0, vld_b}, 64'd0);

    // random packets with input gaps (i_last toggles while i_valid is low)
    for (int p = 0; p < 25; p++) begin
      len  = int'($urandom_range(1, 12));
      qsum = 0;
      for (int k = 0; k < len; k++) begin
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
          in_last = 1'($urandom_range(0, 1));
          tick;
        end
        in_last = 1'b0;
        q    = int'($urandom_range(0, 8000)) - 4000;
        qsum += q;
        send(q_to_fp(q), (k == len - 1));
      end
      take("rand", q_to_fp(qsum), 32'hFFFFFFFF, len, int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
